// File: rtl/addsub_pipe.sv
// addsub_pipe: segmented-carry pipelined two's-complement adder/subtractor with valid/ready backpressure.
// Optional feature macro ADDSUB_SATURATE_EN clamps overflowing results to the signed limit.
module addsub_pipe #(
  parameter int WIDTH = 8,
  parameter int NSEG  = 2
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int               SEG_W    = WIDTH / NSEG;
  localparam logic [WIDTH:0]   ONE      = 1;
  localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'((ONE << SEG_W) - ONE);

  if (WIDTH < 2 || NSEG < 1 || (WIDTH % NSEG) != 0) begin : g_bad_params
    $error("addsub_pipe: WIDTH must be >= 2 and a multiple of NSEG");
  end

  logic             en;
  logic             src_vld [NSEG];
  logic [WIDTH-1:0] src_acc [NSEG];
  logic [WIDTH-1:0] src_bop [NSEG];
  logic             src_cry [NSEG];
  logic [WIDTH-1:0] nxt_acc [NSEG];
  logic             nxt_cry [NSEG];

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  assign src_vld[0] = in_valid;
  assign src_acc[0] = a;
  assign src_bop[0] = op[0] ? ~b : b;
  assign src_cry[0] = op[1] ? cin : op[0];

  // The acc word holds finished result segments below the current stage and
  // untouched A segments above it, so one register serves as both skew and deskew.
  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [SEG_W:0] seg_sum;

    assign seg_sum = {1'b0, SEG_W'(src_acc[k] >> (k * SEG_W))}
                   + {1'b0, SEG_W'(src_bop[k] >> (k * SEG_W))}
                   + (SEG_W + 1)'(src_cry[k]);

    assign nxt_acc[k] = (src_acc[k] & ~(SEG_MASK << (k * SEG_W)))
                      | (WIDTH'(seg_sum[SEG_W-1:0]) << (k * SEG_W));
    assign nxt_cry[k] = seg_sum[SEG_W];

    if (k < NSEG - 1) begin : g_reg
      logic             vld_q;
      logic [WIDTH-1:0] acc_q;
      logic [WIDTH-1:0] bop_q;
      logic             cry_q;

      always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          acc_q <= '0;
          bop_q <= '0;
          cry_q <= 1'b0;
        end else if (en) begin
          vld_q <= src_vld[k];
          acc_q <= nxt_acc[k];
          bop_q <= src_bop[k];
          cry_q <= nxt_cry[k];
        end
      end

      assign src_vld[k+1] = vld_q;
      assign src_acc[k+1] = acc_q;
      assign src_bop[k+1] = bop_q;
      assign src_cry[k+1] = cry_q;
    end
  end

  // The top segment of acc still carries A until the final stage, so its MSB is A's sign.
  logic             a_msb;
  logic             b_msb;
  logic             ovf_d;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] sum_d;

  assign a_msb = src_acc[NSEG-1][WIDTH-1];
  assign b_msb = src_bop[NSEG-1][WIDTH-1];
  assign raw   = nxt_acc[NSEG-1];
  assign ovf_d = (a_msb == b_msb) & (raw[WIDTH-1] != a_msb);

`ifdef ADDSUB_SATURATE_EN
  assign sum_d = ovf_d ? {a_msb, {(WIDTH-1){~a_msb}}} : raw;
`else
  assign sum_d = raw;
`endif

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= src_vld[NSEG-1];
      sum       <= sum_d;
      cout      <= nxt_cry[NSEG-1];
      ovf       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: scoreboard bench for addsub_pipe (WIDTH=8, NSEG=2) with directed vectors.
// Expected overflow sums follow ADDSUB_SATURATE_EN when it is defined for the build.
module tb_addsub_pipe;

  logic       ck = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] exp_q[$];

`ifdef ADDSUB_SATURATE_EN
  localparam logic [7:0] SUM_7F_01 = 8'h7F;
  localparam logic [7:0] SUM_80_01 = 8'h80;
  localparam logic [7:0] SUM_80_80 = 8'h80;
`else
  localparam logic [7:0] SUM_7F_01 = 8'h80;
  localparam logic [7:0] SUM_80_01 = 8'h7F;
  localparam logic [7:0] SUM_80_80 = 8'h00;
`endif

  addsub_pipe #(.WIDTH(8), .NSEG(2)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 ck = ~ck;

  task automatic check_output(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, record the expected {sum,cout,ovf}.
  task automatic apply_stimulus(input logic [7:0] va, input logic [7:0] vb, input logic [1:0] vop,
                                input logic vcin, input logic [9:0] vexp);
    bit accepted = 1'b0;
    a        = va;
    b        = vb;
    op       = vop;
    cin      = vcin;
    in_valid = 1'b1;
    for (int w = 0; w < 20 && !accepted; w++) begin
      @(negedge ck);
      if (in_ready) begin
        exp_q.push_back(vexp);
        accepted = 1'b1;
      end
      @(posedge ck);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept timeout: a=%h b=%h never accepted", va, vb);
    end
  endtask

  task automatic wait_drain();
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) begin
      @(posedge ck);
      #1;
    end
    check_output("drain pending", 10'(exp_q.size()), 10'd0);
  endtask

  // Monitor: compare the head of the scoreboard on every valid output cycle, pop on handshake.
  always @(negedge ck) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected result: got %h, expected none at %0t", {sum, cout, ovf}, $time);
      end else begin
        check_output("result", {sum, cout, ovf}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    op        = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    #2;
    check_output("reset outputs", {sum, cout, ovf}, 10'd0);
    check_output("reset out_valid", 10'(out_valid), 10'd0);
    #11 rst_n = 1'b1;
    @(posedge ck);
    #1;
    check_output("idle in_ready", 10'(in_ready), 10'd1);

    apply_stimulus(8'hFF, 8'h01, 2'b00, 1'b0, {8'h00, 1'b1, 1'b0});
    check_output("latency edge t", 10'(out_valid), 10'd0);
    @(posedge ck);
    #1;
    check_output("latency edge t+1", 10'(out_valid), 10'd1);
    @(posedge ck);
    #1;

    apply_stimulus(8'h7F, 8'h01, 2'b00, 1'b0, {SUM_7F_01, 1'b0, 1'b1});
    apply_stimulus(8'h05, 8'h07, 2'b01, 1'b0, {8'hFE, 1'b0, 1'b0});
    apply_stimulus(8'h80, 8'h01, 2'b01, 1'b0, {SUM_80_01, 1'b1, 1'b1});
    apply_stimulus(8'h10, 8'h20, 2'b10, 1'b1, {8'h31, 1'b0, 1'b0});
    apply_stimulus(8'h10, 8'h05, 2'b11, 1'b0, {8'h0A, 1'b1, 1'b0});
    apply_stimulus(8'h00, 8'h00, 2'b11, 1'b1, {8'h00, 1'b1, 1'b0});
    apply_stimulus(8'h80, 8'h80, 2'b00, 1'b0, {SUM_80_80, 1'b1, 1'b1});
    apply_stimulus(8'h10, 8'h20, 2'b10, 1'b0, {8'h30, 1'b0, 1'b0});
    wait_drain();

    fork
      begin
        for (int i = 0; i < 6; i++)
          apply_stimulus(8'(i), 8'(i), 2'b00, 1'b0, {8'(2 * i), 2'b00});
      end
      begin
        repeat (3) @(posedge ck);
        #1 out_ready = 1'b0;
        @(negedge ck);
        check_output("stall in_ready", 10'(in_ready), 10'd0);
        repeat (3) @(posedge ck);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    apply_stimulus(8'h01, 8'h02, 2'b00, 1'b0, {8'h03, 2'b00});
    apply_stimulus(8'h03, 8'h04, 2'b00, 1'b0, {8'h07, 2'b00});
    #3 rst_n = 1'b0;
    #1;
    check_output("mid reset outputs", {sum, cout, ovf}, 10'd0);
    check_output("mid reset out_valid", 10'(out_valid), 10'd0);
    exp_q.delete();
    #7 rst_n = 1'b1;
    @(posedge ck);
    #1;
    check_output("post reset in_ready", 10'(in_ready), 10'd1);
    apply_stimulus(8'h22, 8'h11, 2'b00, 1'b0, {8'h33, 2'b00});
    check_output("post reset latency t", 10'(out_valid), 10'd0);
    @(posedge ck);
    #1;
    check_output("post reset latency t+1", 10'(out_valid), 10'd1);
    wait_drain();
    repeat (3) @(posedge ck);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the convolution datapath.
- Successor to the fixed 4-bit clocked adder core.
- Operand width and carry-chain pipelining are set by parameters; op select covers add or subtract, with or without external carry.
- Valid/ready handshake with backpressure lets it sit between MAC partial-sum stages without external FIFOs.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- NSEG, 2, number of carry-chain segments, which is also the pipeline latency. WIDTH % NSEG must be 0, otherwise elaboration fails. SEG_W = WIDTH/NSEG.

Ports:
- ck  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  2  op[0]=1 subtract; op[1]=1 use cin, else implicit carry (0 for add, 1 for sub)
- cin  in  1  external carry-in (active-high carry; for sub, 1 = no borrow)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (sub: 1 = no borrow)
- ovf  out  1  signed overflow

Behaviour:
- Reset: rst_n low asynchronously clears all valid bits and all data registers. out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 while reset is deasserted and the pipe is empty.
- Operation: b_eff = op[0] ? ~b : b. c0 = op[1] ? cin : op[0]. Result = a + b_eff + c0, computed over WIDTH+1 bits.
- Pipeline: stage k (k=1..NSEG) adds segment k-1 (bits k*SEG_W-1 : (k-1)*SEG_W) using the registered carry from stage k-1. Stage 1 uses c0.
  - Upper operand segments are skewed by delay registers.
  - Completed lower result segments are deskewed by delay registers.
- Latency: a beat accepted at edge t appears on sum/cout/ovf with out_valid=1 after edge t+NSEG-1. This holds when never stalled.
- Throughput: one beat per cycle.
- Advance enable: en = ~out_valid | out_ready. in_ready = en, combinational.
  - Beat accepted iff in_valid & in_ready.
  - When en=0, every stage register, valid bit and output holds.
- Bubbles: when in_valid=0 and en=1, a valid=0 slot enters the pipe. Data registers may update, but out_valid tracks the valid bits exactly.
- Outputs registered. sum/cout/ovf are stable while out_valid & ~out_ready.
- cout = carry out of the top segment.
- ovf = (a[MSB] == b_eff[MSB]) & (raw_sum[MSB] != a[MSB]). Sign bits are carried through the pipeline.
- Simultaneous events: when the output is consumed and a new beat is accepted in the same cycle, both occur; no bubble is inserted.
- Reset mid-operation: all in-flight beats are discarded. The first post-reset result belongs to the first beat accepted after release.
- NSEG=1: single-stage registered add, latency 1.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when ovf=1, sum is clamped to the signed limit. The limit is 0 followed by WIDTH-1 ones when a[MSB]=0, and 1 followed by WIDTH-1 zeros when a[MSB]=1. ovf and cout still report the raw condition. The clamp sits in the final stage; latency is unchanged.
- Undefined: sum is the raw wrapped result; no clamp logic is generated.

Test Plan (WIDTH=8, NSEG=2, out_ready=1 unless stated):
- Add a=FF b=01 op=00 -> two cycles later out_valid=1, sum=00, cout=1, ovf=0 (exercises carry across the segment boundary).
- Add a=7F b=01 op=00 -> sum=80, ovf=1, cout=0. With ADDSUB_SATURATE_EN: sum=7F, ovf=1.
- Subtract:
  - a=05 b=07 op=01 -> sum=FE, cout=0, ovf=0.
  - a=80 b=01 op=01 -> sum=7F, ovf=1; with ADDSUB_SATURATE_EN: sum=80.
- Carry-in: a=10 b=20 op=10 cin=1 -> sum=31. Then a=10 b=05 op=11 cin=0 -> sum=0A, cout=1.
- Backpressure: stream 6 back-to-back beats (a=i, b=i, i=0..5) and hold out_ready=0 for 3 cycles mid-stream -> in_ready drops; results 00,02,04,06,08,0A emerge in order with none lost or duplicated; sum holds while stalled.
- Reset mid-flight: 2 beats in the pipe, pulse rst_n low asynchronously (not edge-aligned) -> outputs clear immediately, those beats never appear, and the next accepted beat appears after 2 cycles.
